// File: rtl/counter_ctrl.sv
// Prescaled up/down counter with start/stop/pause/load control.
// Continuous (wrapping) or one-shot mode; every output is a flop.
module counter_ctrl #(
  parameter int DIV_W = 32,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic [DIV_W-1:0] div_val,
  input  logic             mode,
  input  logic             dir,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tick_o,
  output logic             wrap_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_pre;
  logic [DIV_W-1:0] r_div;
  logic             r_mode;
  logic             r_dir;
  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;
  logic             r_wrap;
  logic             r_busy;
  logic             r_done;

  logic             w_pre_term;
  logic [CNT_W-1:0] w_next;
  logic             w_step_wraps;
  logic             w_next_at_end;
  logic             w_start_done;

  assign w_pre_term    = (r_pre == r_div);
  assign w_next        = r_dir ? (r_cnt - 1'b1) : (r_cnt + 1'b1);
  assign w_step_wraps  = r_dir ? (r_cnt == '0) : (r_cnt == '1);
  assign w_next_at_end = r_dir ? (w_next == '0) : (w_next == '1);
  // Start decision uses the live mode/dir since they are latched on that same edge.
  assign w_start_done  = mode & (dir ? (r_cnt == '0) : (r_cnt == '1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pre   <= '0;
      r_div   <= '0;
      r_mode  <= 1'b0;
      r_dir   <= 1'b0;
      r_cnt   <= '0;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (stop) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
          end else if (load) begin
            r_cnt   <= load_val;
            r_state <= IDLE;
            r_done  <= 1'b0;
          end else if (start) begin
            r_div  <= div_val;
            r_mode <= mode;
            r_dir  <= dir;
            r_pre  <= '0;
            if (w_start_done) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= RUN;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
            end
          end
        end
        RUN: begin
          if (stop) begin
            r_state <= IDLE;
            r_pre   <= '0;
            r_busy  <= 1'b0;
          end else begin
            if (w_pre_term) begin
              r_pre  <= '0;
              r_cnt  <= w_next;
              r_tick <= 1'b1;
              r_wrap <= ~r_mode & w_step_wraps;
            end else begin
              r_pre <= r_pre + 1'b1;
            end
            // Reaching the one-shot terminal outranks a concurrent pause.
            if (w_pre_term && r_mode && w_next_at_end) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else if (pause) begin
              r_state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (stop) begin
            r_state <= IDLE;
            r_pre   <= '0;
            r_busy  <= 1'b0;
          end else if (!pause) begin
            r_state <= RUN;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cnt_o  = r_cnt;
  assign tick_o = r_tick;
  assign wrap_o = r_wrap;
  assign busy_o = r_busy;
  assign done_o = r_done;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl: one task per scenario, hand-computed expectations.
module tb_counter_ctrl;
  localparam int DIV_W = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0, stop = 1'b0, pause = 1'b0, load = 1'b0;
  logic             mode = 1'b0, dir = 1'b0;
  logic [CNT_W-1:0] load_val = '0;
  logic [DIV_W-1:0] div_val = '0;
  logic [CNT_W-1:0] cnt_o;
  logic             tick_o, wrap_o, busy_o, done_o;

  int n_chk = 0;
  int n_pass = 0;

  counter_ctrl #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
    .load(load), .load_val(load_val), .div_val(div_val), .mode(mode), .dir(dir),
    .cnt_o(cnt_o), .tick_o(tick_o), .wrap_o(wrap_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_chk++; if (cnt_o !== 4'd0) $display("FAIL rst_cnt got %0d want 0", cnt_o); else n_pass++;
    n_chk++; if (tick_o !== 1'b0) $display("FAIL rst_tick got %b want 0", tick_o); else n_pass++;
    n_chk++; if (wrap_o !== 1'b0) $display("FAIL rst_wrap got %b want 0", wrap_o); else n_pass++;
    n_chk++; if (busy_o !== 1'b0) $display("FAIL rst_busy got %b want 0", busy_o); else n_pass++;
    n_chk++; if (done_o !== 1'b0) $display("FAIL rst_done got %b want 0", done_o); else n_pass++;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_up_wrap();
    load_val = 4'd14; load = 1'b1; cyc(); load = 1'b0;
    n_chk++; if (cnt_o !== 4'd14) $display("FAIL up_load got %0d want 14", cnt_o); else n_pass++;
    div_val = 3; mode = 1'b0; dir = 1'b0; start = 1'b1; cyc(); start = 1'b0;
    // Changes while busy must be ignored.
    div_val = 0; mode = 1'b1; dir = 1'b1;
    n_chk++; if (busy_o !== 1'b1) $display("FAIL up_busy got %b want 1", busy_o); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      for (int q = 0; q < 3; q++) begin
        cyc();
        n_chk++; if (tick_o !== 1'b0) $display("FAIL up_quiet k=%0d q=%0d got %b want 0", k, q, tick_o); else n_pass++;
      end
      cyc();
      n_chk++; if (tick_o !== 1'b1) $display("FAIL up_tick k=%0d got %b want 1", k, tick_o); else n_pass++;
      n_chk++; if (cnt_o !== 4'(15 + k)) $display("FAIL up_cnt k=%0d got %0d want %0d", k, cnt_o, 4'(15 + k)); else n_pass++;
      n_chk++; if (wrap_o !== (k == 1)) $display("FAIL up_wrap k=%0d got %b want %b", k, wrap_o, k == 1); else n_pass++;
    end
    stop = 1'b1; cyc(); stop = 1'b0;
    n_chk++; if (busy_o !== 1'b0) $display("FAIL up_stop_busy got %b want 0", busy_o); else n_pass++;
    n_chk++; if (cnt_o !== 4'd1) $display("FAIL up_stop_cnt got %0d want 1", cnt_o); else n_pass++;
    mode = 1'b0; dir = 1'b0;
  endtask

  task automatic test_oneshot_down();
    load_val = 4'd3; load = 1'b1; cyc(); load = 1'b0;
    mode = 1'b1; dir = 1'b1; div_val = 0; start = 1'b1; cyc(); start = 1'b0;
    n_chk++; if (cnt_o !== 4'd3) $display("FAIL dn_start_cnt got %0d want 3", cnt_o); else n_pass++;
    for (int k = 1; k <= 3; k++) begin
      cyc();
      n_chk++; if (cnt_o !== 4'(3 - k)) $display("FAIL dn_cnt k=%0d got %0d want %0d", k, cnt_o, 3 - k); else n_pass++;
      n_chk++; if (tick_o !== 1'b1) $display("FAIL dn_tick k=%0d got %b want 1", k, tick_o); else n_pass++;
      n_chk++; if (wrap_o !== 1'b0) $display("FAIL dn_wrap k=%0d got %b want 0", k, wrap_o); else n_pass++;
      n_chk++; if (done_o !== (k == 3)) $display("FAIL dn_done k=%0d got %b want %b", k, done_o, k == 3); else n_pass++;
      n_chk++; if (busy_o !== (k != 3)) $display("FAIL dn_busy k=%0d got %b want %b", k, busy_o, k != 3); else n_pass++;
    end
    cyc();
    n_chk++; if (tick_o !== 1'b0) $display("FAIL dn_hold_tick got %b want 0", tick_o); else n_pass++;
    n_chk++; if (cnt_o !== 4'd0) $display("FAIL dn_hold_cnt got %0d want 0", cnt_o); else n_pass++;
    n_chk++; if (done_o !== 1'b1) $display("FAIL dn_hold_done got %b want 1", done_o); else n_pass++;
    stop = 1'b1; cyc(); stop = 1'b0;
    n_chk++; if (done_o !== 1'b0) $display("FAIL dn_stop_done got %b want 0", done_o); else n_pass++;
    mode = 1'b0; dir = 1'b0;
  endtask

  task automatic test_pause();
    div_val = 5; start = 1'b1; cyc(); start = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      pause = (i >= 2 && i <= 11);
      cyc();
      n_chk++; if (tick_o !== (i == 16)) $display("FAIL pause_tick i=%0d got %b want %b", i, tick_o, i == 16); else n_pass++;
      if (i == 6) begin
        n_chk++; if (busy_o !== 1'b1) $display("FAIL pause_busy got %b want 1", busy_o); else n_pass++;
      end
    end
    pause = 1'b0;
    n_chk++; if (cnt_o !== 4'd1) $display("FAIL pause_cnt got %0d want 1", cnt_o); else n_pass++;
    stop = 1'b1; cyc(); stop = 1'b0;
  endtask

  task automatic test_pause_on_terminal();
    div_val = 0; start = 1'b1; cyc(); start = 1'b0;
    pause = 1'b1; cyc();
    n_chk++; if (tick_o !== 1'b1 || cnt_o !== 4'd2) $display("FAIL pterm_step got tick=%b cnt=%0d want tick=1 cnt=2", tick_o, cnt_o); else n_pass++;
    cyc();
    n_chk++; if (tick_o !== 1'b0 || cnt_o !== 4'd2 || busy_o !== 1'b1) $display("FAIL pterm_hold got tick=%b cnt=%0d busy=%b want 0/2/1", tick_o, cnt_o, busy_o); else n_pass++;
    pause = 1'b0; cyc();
    n_chk++; if (tick_o !== 1'b0 || cnt_o !== 4'd2) $display("FAIL pterm_resume got tick=%b cnt=%0d want 0/2", tick_o, cnt_o); else n_pass++;
    cyc();
    n_chk++; if (tick_o !== 1'b1 || cnt_o !== 4'd3) $display("FAIL pterm_run got tick=%b cnt=%0d want 1/3", tick_o, cnt_o); else n_pass++;
    stop = 1'b1; cyc(); stop = 1'b0;
  endtask

  task automatic test_stop_terminal();
    div_val = 2; start = 1'b1; cyc(); start = 1'b0;
    cyc(); cyc();
    n_chk++; if (tick_o !== 1'b0) $display("FAIL sterm_pre got %b want 0", tick_o); else n_pass++;
    stop = 1'b1; cyc(); stop = 1'b0;
    n_chk++; if (tick_o !== 1'b0) $display("FAIL sterm_tick got %b want 0", tick_o); else n_pass++;
    n_chk++; if (cnt_o !== 4'd3) $display("FAIL sterm_cnt got %0d want 3", cnt_o); else n_pass++;
    n_chk++; if (busy_o !== 1'b0) $display("FAIL sterm_busy got %b want 0", busy_o); else n_pass++;
    // Restart: prescaler must begin from zero again.
    start = 1'b1; cyc(); start = 1'b0;
    cyc(); cyc();
    n_chk++; if (tick_o !== 1'b0) $display("FAIL sterm_re_early got %b want 0", tick_o); else n_pass++;
    cyc();
    n_chk++; if (tick_o !== 1'b1 || cnt_o !== 4'd4) $display("FAIL sterm_re_tick got tick=%b cnt=%0d want 1/4", tick_o, cnt_o); else n_pass++;
    stop = 1'b1; cyc(); stop = 1'b0;
  endtask

  task automatic test_oneshot_immediate();
    load_val = 4'd15; load = 1'b1; cyc(); load = 1'b0;
    mode = 1'b1; dir = 1'b0; start = 1'b1; cyc(); start = 1'b0;
    n_chk++; if (done_o !== 1'b1 || busy_o !== 1'b0) $display("FAIL imm_done got done=%b busy=%b want 1/0", done_o, busy_o); else n_pass++;
    n_chk++; if (tick_o !== 1'b0 || cnt_o !== 4'd15) $display("FAIL imm_tick got tick=%b cnt=%0d want 0/15", tick_o, cnt_o); else n_pass++;
    load_val = 4'd7; load = 1'b1; cyc(); load = 1'b0;
    n_chk++; if (done_o !== 1'b0 || busy_o !== 1'b0) $display("FAIL imm_load_state got done=%b busy=%b want 0/0", done_o, busy_o); else n_pass++;
    n_chk++; if (cnt_o !== 4'd7) $display("FAIL imm_load_cnt got %0d want 7", cnt_o); else n_pass++;
    mode = 1'b0;
    load_val = 4'd5; load = 1'b1; start = 1'b1; cyc(); load = 1'b0; start = 1'b0;
    n_chk++; if (cnt_o !== 4'd5 || busy_o !== 1'b0) $display("FAIL ldst got cnt=%0d busy=%b want 5/0", cnt_o, busy_o); else n_pass++;
  endtask

  task automatic test_async_reset();
    div_val = 0; start = 1'b1; cyc(); start = 1'b0;
    cyc();
    n_chk++; if (tick_o !== 1'b1 || cnt_o !== 4'd6) $display("FAIL ar_run got tick=%b cnt=%0d want 1/6", tick_o, cnt_o); else n_pass++;
    #3; rst_n = 1'b0; #1;
    n_chk++; if (cnt_o !== 4'd0 || tick_o !== 1'b0 || busy_o !== 1'b0) $display("FAIL ar_async got cnt=%0d tick=%b busy=%b want 0/0/0", cnt_o, tick_o, busy_o); else n_pass++;
    cyc();
    rst_n = 1'b1;
    cyc();
    n_chk++; if (busy_o !== 1'b0 || tick_o !== 1'b0 || wrap_o !== 1'b0 || cnt_o !== 4'd0) $display("FAIL ar_release got busy=%b tick=%b wrap=%b cnt=%0d want 0/0/0/0", busy_o, tick_o, wrap_o, cnt_o); else n_pass++;
    #3; rst_n = 1'b0; #2;
    start = 1'b1; rst_n = 1'b1;
    cyc(); start = 1'b0;
    n_chk++; if (busy_o !== 1'b1) $display("FAIL ar_first_start got %b want 1", busy_o); else n_pass++;
    stop = 1'b1; cyc(); stop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_oneshot_down();
    test_pause();
    test_pause_on_terminal();
    test_stop_terminal();
    test_oneshot_immediate();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
